// File: rtl/fpa_pkg.sv
// Shared field widths, FSM states and the unpacked-operand record for the FP alignment stage.
package fpa_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int EXT_W     = 27;
    localparam int ALIGN_CAP = 27;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] eff_exp;
        logic [EXT_W-1:0] ext;
        logic             nan;
        logic             inf;
        logic             zero;
    } operand_t;

endpackage

// File: rtl/fpa_align_if.sv
// Operand-in / aligned-record-out handshake bundle between the FP datapath and the alignment stage.
interface fpa_align_if;
    import fpa_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          number_A;
    logic [31:0]          number_B;
    logic                 out_valid;
    logic                 out_ready;
    logic                 big_sign;
    logic [EXP_W-1:0]     big_exp;
    logic [EXT_W-1:0]     big_mant;
    logic                 small_sign;
    logic [EXT_W-1:0]     small_mant;
    logic                 swapped;
    logic                 is_nan;
    logic                 is_inf;

    modport master (
        output in_valid, number_A, number_B, out_ready,
        input  in_ready, out_valid, big_sign, big_exp, big_mant,
               small_sign, small_mant, swapped, is_nan, is_inf
    );

    modport slave (
        input  in_valid, number_A, number_B, out_ready,
        output in_ready, out_valid, big_sign, big_exp, big_mant,
               small_sign, small_mant, swapped, is_nan, is_inf
    );

endinterface

// File: rtl/fpa_unpack.sv
// Combinational unpack/classify of one IEEE-754 single operand.
module fpa_unpack
    import fpa_pkg::*;
(
    input  logic [31:0] number,
    output operand_t    op
);

    logic [EXP_W-1:0]  exp_field;
    logic [FRAC_W-1:0] frac_field;
    logic              hidden;

    assign exp_field  = number[30:23];
    assign frac_field = number[22:0];
    assign hidden     = (exp_field != '0);

    always_comb begin
        op.sign    = number[31];
        // Denormals share the exponent of the smallest normal.
        op.eff_exp = hidden ? exp_field : EXP_W'(1);
        op.ext     = {hidden, frac_field, 3'b000};
        op.nan     = (exp_field == EXP_SPECIAL) && (frac_field != '0);
        op.inf     = (exp_field == EXP_SPECIAL) && (frac_field == '0);
        op.zero    = !hidden && (frac_field == '0);
    end

endmodule

// File: rtl/fpa_align.sv
// Orders two FP operands by magnitude and right-aligns the smaller significand
// SHIFT_STEP bits per cycle, keeping a sticky bit in bit 0.
module fpa_align
    import fpa_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic         clk,
    input  logic         rst,
    fpa_align_if.slave   bus
);

    logic [31:0] operand [2];
    operand_t    op      [2];

    assign operand[0] = bus.number_A;
    assign operand[1] = bus.number_B;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            fpa_unpack u_unpack (
                .number (operand[gi]),
                .op     (op[gi])
            );
        end
    endgenerate

    // Ordering and exponent difference, evaluated on the raw input operands.
    logic             swap;
    logic             big_sign_in;
    logic [EXP_W-1:0] big_exp_in;
    logic [EXT_W-1:0] big_ext_in;
    logic             small_sign_in;
    logic [EXP_W-1:0] small_exp_in;
    logic [EXT_W-1:0] small_ext_in;
    logic             small_zero_in;
    logic [EXP_W-1:0] diff;
    logic             special_in;

    always_comb begin
        swap          = (bus.number_B[30:0] > bus.number_A[30:0]);
        big_sign_in   = swap ? op[1].sign    : op[0].sign;
        big_exp_in    = swap ? op[1].eff_exp : op[0].eff_exp;
        big_ext_in    = swap ? op[1].ext     : op[0].ext;
        small_sign_in = swap ? op[0].sign    : op[1].sign;
        small_exp_in  = swap ? op[0].eff_exp : op[1].eff_exp;
        small_ext_in  = swap ? op[0].ext     : op[1].ext;
        small_zero_in = swap ? op[0].zero    : op[1].zero;
        diff          = big_exp_in - small_exp_in;
        special_in    = op[0].nan | op[1].nan | op[0].inf | op[1].inf;
    end

    state_t           state_reg;
    logic [EXP_W-1:0] rem_reg;
    logic             big_sign_reg;
    logic [EXP_W-1:0] big_exp_reg;
    logic [EXT_W-1:0] big_mant_reg;
    logic             small_sign_reg;
    logic [EXT_W-1:0] small_mant_reg;
    logic             swapped_reg;
    logic             is_nan_reg;
    logic             is_inf_reg;

    // One shift step: k bits out, everything lost (plus the old sticky) folds into bit 0.
    logic [EXP_W-1:0] step_k;
    logic [EXT_W-1:0] step_mask;
    logic [EXT_W-1:0] step_shifted;
    logic [EXT_W-1:0] small_mant_next;

    always_comb begin
        step_k          = (rem_reg < EXP_W'(SHIFT_STEP)) ? rem_reg : EXP_W'(SHIFT_STEP);
        step_mask       = (EXT_W'(1) << step_k) - EXT_W'(1);
        step_shifted    = small_mant_reg >> step_k;
        small_mant_next = {step_shifted[EXT_W-1:1],
                           step_shifted[0] | (|(small_mant_reg & step_mask))};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            rem_reg        <= '0;
            big_sign_reg   <= 1'b0;
            big_exp_reg    <= '0;
            big_mant_reg   <= '0;
            small_sign_reg <= 1'b0;
            small_mant_reg <= '0;
            swapped_reg    <= 1'b0;
            is_nan_reg     <= 1'b0;
            is_inf_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        rem_reg        <= diff;
                        big_sign_reg   <= big_sign_in;
                        big_exp_reg    <= big_exp_in;
                        big_mant_reg   <= big_ext_in;
                        small_sign_reg <= small_sign_in;
                        swapped_reg    <= swap;
                        is_nan_reg     <= op[0].nan | op[1].nan;
                        is_inf_reg     <= (op[0].inf | op[1].inf) & ~(op[0].nan | op[1].nan);
                        if (special_in || diff == '0) begin
                            small_mant_reg <= small_ext_in;
                            state_reg      <= DONE;
                        end else if (diff >= EXP_W'(ALIGN_CAP)) begin
                            // Fully shifted out: only the sticky survives.
                            small_mant_reg <= {{(EXT_W-1){1'b0}}, ~small_zero_in};
                            state_reg      <= DONE;
                        end else begin
                            small_mant_reg <= small_ext_in;
                            state_reg      <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    small_mant_reg <= small_mant_next;
                    rem_reg        <= rem_reg - step_k;
                    if (rem_reg == step_k) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_reg == IDLE) && !rst;
    assign bus.out_valid  = (state_reg == DONE);
    assign bus.big_sign   = big_sign_reg;
    assign bus.big_exp    = big_exp_reg;
    assign bus.big_mant   = big_mant_reg;
    assign bus.small_sign = small_sign_reg;
    assign bus.small_mant = small_mant_reg;
    assign bus.swapped    = swapped_reg;
    assign bus.is_nan     = is_nan_reg;
    assign bus.is_inf     = is_inf_reg;

endmodule

// File: tb/tb_fpa_align.sv
// Directed-vector bench for fpa_align with SHIFT_STEP = 4.
module tb_fpa_align;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fpa_align_if bus ();

    fpa_align #(.SHIFT_STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.number_A = a;
        bus.number_B = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Latency counted from the accept edge; 1 means out_valid is up right after it.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] exp_sw,
                       input logic [31:0] exp_bs, input logic [31:0] exp_be,
                       input logic [31:0] exp_bm, input logic [31:0] exp_ss,
                       input logic [31:0] exp_sm, input logic [31:0] exp_nan,
                       input logic [31:0] exp_inf);
        int lat;
        start(a, b);
        wait_valid(lat);
        check({tag, "_latency"},    32'(lat), 32'(exp_lat));
        check({tag, "_swapped"},    32'(bus.swapped), exp_sw);
        check({tag, "_big_sign"},   32'(bus.big_sign), exp_bs);
        check({tag, "_big_exp"},    32'(bus.big_exp), exp_be);
        check({tag, "_big_mant"},   32'(bus.big_mant), exp_bm);
        check({tag, "_small_sign"}, 32'(bus.small_sign), exp_ss);
        check({tag, "_small_mant"}, 32'(bus.small_mant), exp_sm);
        check({tag, "_is_nan"},     32'(bus.is_nan), exp_nan);
        check({tag, "_is_inf"},     32'(bus.is_inf), exp_inf);
        $display("[TB] txn %s A=%08h B=%08h lat=%0d swapped=%0d big_exp=%0d big_mant=%07h small_mant=%07h nan=%0d inf=%0d",
                 tag, a, b, lat, bus.swapped, bus.big_exp, bus.big_mant, bus.small_mant,
                 bus.is_nan, bus.is_inf);
        release_out();
    endtask

    initial begin
        int lat;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.number_A  = '0;
        bus.number_B  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_small_mant", 32'(bus.small_mant), 32'd0);
        check("reset_big_exp", 32'(bus.big_exp), 32'd0);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        //  tag        A             B             lat sw bs be   big_mant      ss small_mant    nan inf
        run("d4_sticky", 32'h41800000, 32'h3F800001, 2, 0, 0, 131, 32'h4000000, 0, 32'h0400001, 0, 0);
        run("d1_swap",   32'h3F800000, 32'hC0000000, 2, 1, 1, 128, 32'h4000000, 0, 32'h2000000, 0, 0);
        run("d0_equal",  32'h3F800000, 32'h3F800000, 1, 0, 0, 127, 32'h4000000, 0, 32'h4000000, 0, 0);
        run("d30_cap",   32'h4E800000, 32'h3F800000, 1, 0, 0, 157, 32'h4000000, 0, 32'h0000001, 0, 0);
        run("d26_worst", 32'h4C800000, 32'h3F800000, 8, 0, 0, 153, 32'h4000000, 0, 32'h0000001, 0, 0);
        run("d5_two",    32'h42000000, 32'h3F800001, 3, 0, 0, 132, 32'h4000000, 0, 32'h0200001, 0, 0);
        run("nan",       32'h7FC00000, 32'h3F800000, 1, 0, 0, 255, 32'h6000000, 0, 32'h4000000, 1, 0);
        run("inf_swap",  32'h3F800000, 32'hFF800000, 1, 1, 1, 255, 32'h4000000, 0, 32'h4000000, 0, 1);
        run("denorm",    32'h00000001, 32'h00800000, 1, 1, 0, 1,   32'h4000000, 0, 32'h0000008, 0, 0);

        // Backpressure: hold DONE while the input side churns.
        start(32'h41800000, 32'h3F800001);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0] ? 1'b0 : 1'b1;
            bus.number_A = $urandom;
            bus.number_B = $urandom;
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_small_mant", 32'(bus.small_mant), 32'h0400001);
            check("bp_big_exp", 32'(bus.big_exp), 32'd131);
        end
        bus.in_valid = 1'b0;
        $display("[TB] txn backpressure held 5 cycles small_mant=%07h", bus.small_mant);
        release_out();
        check("bp_after_release_small_mant", 32'(bus.small_mant), 32'h0400001);

        // Reset in the middle of a long shift.
        start(32'h4C800000, 32'h3F800000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_small_mant", 32'(bus.small_mant), 32'd0);
        check("rst_mid_big_exp", 32'(bus.big_exp), 32'd0);
        check("rst_mid_big_mant", 32'(bus.big_mant), 32'd0);
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_mid_in_ready_after", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("rst_mid_no_pulse", 32'(bus.out_valid), 32'd0);
        end
        $display("[TB] txn reset_mid_shift out_valid=%0d in_ready=%0d", bus.out_valid, bus.in_ready);

        run("post_rst", 32'h3F800000, 32'h40000000, 2, 1, 0, 128, 32'h4000000, 0, 32'h2000000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpa_align.md
# fpa_align

Multi-cycle operand alignment stage that sits directly upstream of the `fpa` adder core in the floating-point datapath. It accepts two IEEE-754 single-precision operands over a valid/ready handshake and classifies them. It orders them by magnitude, then right-shifts the smaller significand by the exponent difference, SHIFT_STEP bits per cycle, while preserving a sticky bit. The aligned record is presented to the adder core over a second valid/ready handshake.

## Interface
- SHIFT_STEP, 4, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- number_A  in  32  IEEE-754 single operand A.
- number_B  in  32  IEEE-754 single operand B.
- out_valid  out  1  aligned record valid.
- out_ready  in  1  downstream accepts the record.
- big_sign  out  1  sign of the larger-magnitude operand.
- big_exp  out  8  effective exponent of the larger operand.
- big_mant  out  27  {hidden, frac[22:0], 3'b000} of the larger operand.
- small_sign  out  1  sign of the smaller operand.
- small_mant  out  27  aligned smaller significand; bit 0 is sticky.
- swapped  out  1  1 when B was the larger operand.
- is_nan  out  1  either operand is NaN.
- is_inf  out  1  either operand is ±inf and neither is NaN.

## Operation
- Unpack each operand:
  - E = [30:23], F = [22:0].
  - Hidden bit = (E != 0).
  - Effective exponent = (E == 0) ? 1 : E.
  - Extended significand = {hidden, F, 3'b000}.
- Ordering:
  - Compare magnitude {E, F} unsigned.
  - B strictly greater: swap, swapped = 1.
  - Equal magnitudes: no swap.
- d = effexp_big − effexp_small, 8-bit unsigned, range 0..253.
- Specials:
  - NaN: E = 255 and F != 0.
  - Inf: E = 255 and F = 0.
  - If either flag is set, no shift is performed.
  - small_mant is passed unshifted and the block goes straight to DONE.
- States:
  - IDLE: in_ready = 1. On in_valid, capture the unpacked, ordered operands and set remaining = d.
    - Go to DONE if d = 0, a special is present, or d ≥ 27. When d ≥ 27, small_mant = {26'b0, |small_ext}.
    - Otherwise go to SHIFT.
  - SHIFT: each cycle, k = min(remaining, SHIFT_STEP).
    - small_mant ← small_mant >> k, with bit 0 OR-ed with all k bits shifted out and the old bit 0.
    - remaining ← remaining − k.
    - When remaining reaches 0, go to DONE.
  - DONE: out_valid = 1 and all outputs held stable. When out_ready is high, go to IDLE.
- in_ready = 1 only in IDLE with rst low; combinational from state.
- in_valid is ignored outside IDLE, and no operand is buffered.
- No mid-operation abort other than rst.

## Timing
- Accept edge at E0: out_valid rises at E0 + 1 + ceil(d'/SHIFT_STEP).
  - d' = 0 when d = 0, a special is present, or d ≥ 27; otherwise d' = d.
- Worst case at SHIFT_STEP = 4: d = 26 gives 7 shift cycles and out_valid 8 cycles after accept.
- Release edge at E1 (out_valid && out_ready): in_ready is high in the cycle after E1. Back-to-back throughput is at best one pair every 2 cycles.
- Reset values: state IDLE, out_valid 0, all data and flag outputs 0, in_ready 0 while rst is high.
- rst mid-SHIFT or in DONE discards the transaction, with no output pulse.
- out_ready high while out_valid is low has no effect.

## Structure
- fpa_pkg holds:
  - field widths (EXP_W = 8, FRAC_W = 23, EXT_W = 27);
  - state enum {IDLE, SHIFT, DONE};
  - EXP_SPECIAL = 8'hFF and the alignment cap ALIGN_CAP = 27.
- Sub-module fpa_unpack: combinational per-operand unpack and classify (eff_exp, ext significand, nan, inf, zero). It is instantiated twice. The FSM, compare, swap and shifter live in fpa_align.

## Test plan
- A=0x41800000, B=0x3F800001, SHIFT_STEP=4 (d=4, sticky set) -> swapped=0, big_exp=131, big_mant=0x4000000, small_mant=0x0400001; out_valid 2 cycles after accept.
- A=0x3F800000, B=0x40000000 (d=1, swap) -> swapped=1, big_exp=128, big_mant=0x4000000, small_mant=0x2000000; out_valid 2 cycles after accept.
- A=B=0x3F800000 (d=0) -> swapped=0, small_mant=0x4000000; out_valid 1 cycle after accept.
- A=0x4E800000, B=0x3F800000 (d=30, capped) -> small_mant=0x0000001; out_valid 1 cycle after accept.
- A=0x7FC00000, B=0x3F800000 -> is_nan=1, is_inf=0, no SHIFT state; out_valid 1 cycle after accept.
- Backpressure and reset:
  - Hold out_ready low for 5 cycles in DONE while toggling in_valid and operands -> outputs stable, in_ready=0, new operands not captured.
  - Assert rst during SHIFT -> next cycle out_valid=0, outputs 0, and in_ready=1 once rst is low.
